// File: rtl/commit_trace_pkg.sv
// Shared types for the commit-trace transmitter: record kinds, field widths, packed record.
// Record carries a cycle stamp only when COMMIT_TRACE_CYCLE_STAMP_EN is defined.
package commit_trace_pkg;

  localparam logic [2:0] KIND_NOP  = 3'd0;
  localparam logic [2:0] KIND_REG  = 3'd1;
  localparam logic [2:0] KIND_LD   = 3'd2;
  localparam logic [2:0] KIND_STU  = 3'd3;
  localparam logic [2:0] KIND_ST   = 3'd4;
  localparam logic [2:0] KIND_HALT = 3'd5;

  localparam int KIND_W       = 3;
  localparam int INUM_FIELD_W = 16;  // widest supported INUM_W
  localparam int XLEN         = 16;
  localparam int REG_W        = 3;
  localparam int CYCLE_W      = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [KIND_W-1:0]       kind;
    logic [INUM_FIELD_W-1:0] inum;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         inst;
    logic [REG_W-1:0]        wreg;
    logic [XLEN-1:0]         wdata;
    logic [XLEN-1:0]         addr;
    logic [XLEN-1:0]         mdata;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    logic [CYCLE_W-1:0]      cycle;
`endif
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/commit_trace_tx_if.sv
// Record stream from the commit-trace transmitter to a trace sink (valid/ready).
// master = transmitter, slave = sink; payload is held stable while valid && !ready.
interface commit_trace_tx_if #(
  parameter int INUM_W = 16
);
  logic              rec_valid;
  logic              rec_ready;
  logic [2:0]        rec_kind;
  logic [INUM_W-1:0] rec_inum;
  logic [15:0]       rec_pc;
  logic [15:0]       rec_inst;
  logic [2:0]        rec_wreg;
  logic [15:0]       rec_wdata;
  logic [15:0]       rec_addr;
  logic [15:0]       rec_mdata;
  logic [31:0]       rec_cycle;

  modport master (
    output rec_valid, rec_kind, rec_inum, rec_pc, rec_inst, rec_wreg,
           rec_wdata, rec_addr, rec_mdata, rec_cycle,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_kind, rec_inum, rec_pc, rec_inst, rec_wreg,
           rec_wdata, rec_addr, rec_mdata, rec_cycle,
    output rec_ready
  );
endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO, registered head, one-cycle push-to-visible latency, no bypass.
// Push while full and pop while empty are ignored; full/empty come from the occupancy register.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is read past the occupancy count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: classifies, numbers and buffers retired instructions; records appear one cycle after push.
// commit_stall = FIFO full; after a HALT record drains the block idles until rst. Cycle stamps under COMMIT_TRACE_CYCLE_STAMP_EN.
module commit_trace_tx
  import commit_trace_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int INUM_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit_valid,
  input  logic [15:0]             commit_pc,
  input  logic [15:0]             commit_inst,
  input  logic                    reg_write,
  input  logic [2:0]              write_reg,
  input  logic [15:0]             write_data,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [15:0]             mem_addr,
  input  logic [15:0]             mem_data,
  input  logic                    halt,
  output logic                    commit_stall,
  output logic                    halted,
  commit_trace_tx_if.master       rec_if
);

  tx_state_e         state_q;
  logic              halted_q;
  logic [INUM_W-1:0] inum_q, inum_d;
  logic [2:0]        kind;
  logic              has_wreg, has_addr, has_mdata;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  trace_rec_t        push_rec;
  trace_rec_t        head_rec;
  logic [REC_W-1:0]  head_dat;

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  assign cycle_d = cycle_q + 32'd1;
`endif

  always_comb begin
    kind = KIND_NOP;
    if (reg_write && mem_write)     kind = KIND_STU;
    else if (reg_write && mem_read) kind = KIND_LD;
    else if (reg_write)             kind = KIND_REG;
    else if (halt)                  kind = KIND_HALT;
    else if (mem_write)             kind = KIND_ST;
  end

  // Load data arrives through the register write, so only stores carry mdata.
  assign has_wreg  = (kind == KIND_REG) || (kind == KIND_LD) || (kind == KIND_STU);
  assign has_addr  = (kind == KIND_LD) || (kind == KIND_ST) || (kind == KIND_STU);
  assign has_mdata = (kind == KIND_ST) || (kind == KIND_STU);

  always_comb begin
    push_rec       = '0;
    push_rec.kind  = kind;
    push_rec.inum  = INUM_FIELD_W'(inum_q);
    push_rec.pc    = commit_pc;
    push_rec.inst  = commit_inst;
    push_rec.wreg  = has_wreg  ? write_reg  : '0;
    push_rec.wdata = has_wreg  ? write_data : '0;
    push_rec.addr  = has_addr  ? mem_addr   : '0;
    push_rec.mdata = has_mdata ? mem_data   : '0;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    push_rec.cycle = cycle_q;
`endif
  end

  assign commit_stall = fifo_full;
  assign push         = commit_valid && !fifo_full && (state_q == ST_RUN);
  assign pop          = rec_if.rec_valid && rec_if.rec_ready;
  assign inum_d       = push ? inum_q + INUM_W'(1) : inum_q;
  assign halted       = halted_q;

  trace_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_rec),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head_rec = trace_rec_t'(head_dat);

  // Payload is zeroed whenever no record is offered, so idle outputs read 0.
  always_comb begin
    rec_if.rec_valid = !fifo_empty && (state_q != ST_DONE);
    rec_if.rec_kind  = rec_if.rec_valid ? head_rec.kind              : '0;
    rec_if.rec_inum  = rec_if.rec_valid ? head_rec.inum[INUM_W-1:0]  : '0;
    rec_if.rec_pc    = rec_if.rec_valid ? head_rec.pc                : '0;
    rec_if.rec_inst  = rec_if.rec_valid ? head_rec.inst              : '0;
    rec_if.rec_wreg  = rec_if.rec_valid ? head_rec.wreg              : '0;
    rec_if.rec_wdata = rec_if.rec_valid ? head_rec.wdata             : '0;
    rec_if.rec_addr  = rec_if.rec_valid ? head_rec.addr              : '0;
    rec_if.rec_mdata = rec_if.rec_valid ? head_rec.mdata             : '0;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    rec_if.rec_cycle = rec_if.rec_valid ? head_rec.cycle             : '0;
`else
    rec_if.rec_cycle = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inum_q <= '0;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
      cycle_q <= '0;
`endif
    end else begin
      inum_q <= inum_d;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
      cycle_q <= cycle_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (push && (kind == KIND_HALT)) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && (head_rec.kind == KIND_HALT)) begin
            state_q  <= ST_DONE;
            halted_q <= 1'b1;
          end
        end
        ST_DONE: halted_q <= 1'b1;
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx (DEPTH=4, INUM_W=4), outputs sampled 1 time unit after the rising edge.
module tb_commit_trace_tx;
  localparam int INUM_W = 4;

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  localparam logic [31:0] EXP_STAMP7 = 32'd6;
`else
  localparam logic [31:0] EXP_STAMP7 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [15:0] commit_pc, commit_inst;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_data;
  logic        halt;
  logic        commit_stall;
  logic        halted;

  int errors = 0;
  int checks = 0;

  commit_trace_tx_if #(.INUM_W(INUM_W)) rec_if ();

  commit_trace_tx #(
    .DEPTH  (4),
    .INUM_W (INUM_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .halt         (halt),
    .commit_stall (commit_stall),
    .halted       (halted),
    .rec_if       (rec_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic rw,
                       input logic [2:0] wr, input logic [15:0] wd, input logic mr,
                       input logic mw, input logic [15:0] ad, input logic [15:0] md,
                       input logic h);
    commit_valid = v;
    commit_pc    = pc;
    commit_inst  = pc ^ 16'hA5A5;
    reg_write    = rw;
    write_reg    = wr;
    write_data   = wd;
    mem_read     = mr;
    mem_write    = mw;
    mem_addr     = ad;
    mem_data     = md;
    halt         = h;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic reg_commit(input logic [15:0] pc, input logic [15:0] wd);
    drive(1'b1, pc, 1'b1, 3'd1, wd, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_n;
    int npop;
    int halt_c;
    logic accept;

    rec_if.rec_ready = 1'b0;
    rst = 1'b1;
    idle();
    step();
    step();
    chk("rst_valid",  32'(rec_if.rec_valid), 32'd0);
    chk("rst_stall",  32'(commit_stall), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_inum",   32'(rec_if.rec_inum), 32'd0);
    chk("rst_cycle",  rec_if.rec_cycle, 32'd0);
    rst = 1'b0;

    // First commit lands in the 7th cycle after reset release.
    repeat (6) step();
    reg_commit(16'h0002, 16'h00AB);
    write_reg = 3'd3;
    chk("t1_pre_valid", 32'(rec_if.rec_valid), 32'd0);
    step();
    idle();
    chk("t1_valid", 32'(rec_if.rec_valid), 32'd1);
    chk("t1_kind",  32'(rec_if.rec_kind), 32'd1);
    chk("t1_inum",  32'(rec_if.rec_inum), 32'd0);
    chk("t1_pc",    32'(rec_if.rec_pc), 32'h0002);
    chk("t1_inst",  32'(rec_if.rec_inst), 32'h0002 ^ 32'hA5A5);
    chk("t1_wreg",  32'(rec_if.rec_wreg), 32'd3);
    chk("t1_wdata", 32'(rec_if.rec_wdata), 32'h00AB);
    chk("t1_addr",  32'(rec_if.rec_addr), 32'd0);
    chk("t1_cycle", rec_if.rec_cycle, EXP_STAMP7);
    rec_if.rec_ready = 1'b1;
    step();
    chk("t1_popped", 32'(rec_if.rec_valid), 32'd0);

    // Store with stray register fields, then store-update, then load.
    drive(1'b1, 16'h0004, 1'b0, 3'd5, 16'h5555, 1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0);
    step();
    chk("st_kind",  32'(rec_if.rec_kind), 32'd4);
    chk("st_inum",  32'(rec_if.rec_inum), 32'd1);
    chk("st_wreg",  32'(rec_if.rec_wreg), 32'd0);
    chk("st_wdata", 32'(rec_if.rec_wdata), 32'd0);
    chk("st_addr",  32'(rec_if.rec_addr), 32'h0010);
    chk("st_mdata", 32'(rec_if.rec_mdata), 32'h1234);
    drive(1'b1, 16'h0006, 1'b1, 3'd6, 16'h7777, 1'b0, 1'b1, 16'h0020, 16'h4321, 1'b0);
    step();
    chk("stu_kind",  32'(rec_if.rec_kind), 32'd3);
    chk("stu_inum",  32'(rec_if.rec_inum), 32'd2);
    chk("stu_wreg",  32'(rec_if.rec_wreg), 32'd6);
    chk("stu_wdata", 32'(rec_if.rec_wdata), 32'h7777);
    chk("stu_addr",  32'(rec_if.rec_addr), 32'h0020);
    chk("stu_mdata", 32'(rec_if.rec_mdata), 32'h4321);
    drive(1'b1, 16'h0008, 1'b1, 3'd2, 16'hBEEF, 1'b1, 1'b0, 16'h0030, 16'h9999, 1'b0);
    step();
    idle();
    chk("ld_kind",  32'(rec_if.rec_kind), 32'd2);
    chk("ld_inum",  32'(rec_if.rec_inum), 32'd3);
    chk("ld_wdata", 32'(rec_if.rec_wdata), 32'hBEEF);
    chk("ld_addr",  32'(rec_if.rec_addr), 32'h0030);
    chk("ld_mdata", 32'(rec_if.rec_mdata), 32'd0);
    step();
    chk("ld_popped", 32'(rec_if.rec_valid), 32'd0);

    // Back-pressure: five commits into a four-entry buffer with the sink stalled.
    do_reset();
    rec_if.rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      reg_commit(16'h0100 + 16'(i), 16'(i));
      step();
    end
    chk("bp_stall_full", 32'(commit_stall), 32'd1);
    reg_commit(16'h0104, 16'd4);
    repeat (3) step();
    chk("bp_stall_held", 32'(commit_stall), 32'd1);
    chk("bp_head_inum",  32'(rec_if.rec_inum), 32'd0);
    chk("bp_head_pc",    32'(rec_if.rec_pc), 32'h0100);
    rec_if.rec_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 20 && got_n < 5; c++) begin
      if (rec_if.rec_valid) begin
        chk("bp_inum", 32'(rec_if.rec_inum), 32'(got_n));
        chk("bp_pc",   32'(rec_if.rec_pc), 32'h0100 + 32'(got_n));
        got_n++;
      end
      accept = commit_valid && !commit_stall;
      step();
      if (accept) idle();
    end
    chk("bp_count", 32'(got_n), 32'd5);
    chk("bp_nodup", 32'(rec_if.rec_valid), 32'd0);
    chk("bp_unstall", 32'(commit_stall), 32'd0);

    // Halt: REG, HALT, then two commits that must be dropped.
    do_reset();
    rec_if.rec_ready = 1'b1;
    npop = 0;
    halt_c = -1;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: reg_commit(16'h0200, 16'h1111);
        1: drive(1'b1, 16'h0202, 1'b0, 3'd7, 16'h9999, 1'b0, 1'b0, 16'h0040, 16'h0, 1'b1);
        2: reg_commit(16'h0204, 16'h2222);
        3: reg_commit(16'h0206, 16'h3333);
        default: idle();
      endcase
      if (rec_if.rec_valid) begin
        chk("halt_kind", 32'(rec_if.rec_kind), (npop == 0) ? 32'd1 : 32'd5);
        chk("halt_seq_inum", 32'(rec_if.rec_inum), 32'(npop));
        if (rec_if.rec_kind == 3'd5) begin
          halt_c = c;
          chk("halt_wdata", 32'(rec_if.rec_wdata), 32'd0);
          chk("halt_early", 32'(halted), 32'd0);
        end
        npop++;
      end
      step();
      if (c == halt_c) begin
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_novalid", 32'(rec_if.rec_valid), 32'd0);
      end
    end
    chk("halt_count", 32'(npop), 32'd2);
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_idle_valid", 32'(rec_if.rec_valid), 32'd0);

    // Instruction-number wrap with a streaming sink.
    do_reset();
    chk("wrap_rst_halted", 32'(halted), 32'd0);
    rec_if.rec_ready = 1'b1;
    npop = 0;
    for (int c = 0; c < 19; c++) begin
      if (c < 17) reg_commit(16'(c), 16'(c));
      else idle();
      if (rec_if.rec_valid) begin
        if (npop == 16) chk("wrap_inum17", 32'(rec_if.rec_inum), 32'd0);
        else chk("wrap_inum", 32'(rec_if.rec_inum), 32'(npop % 16));
        chk("wrap_nostall", 32'(commit_stall), 32'd0);
        npop++;
      end
      step();
    end
    chk("wrap_count", 32'(npop), 32'd17);

    // Reset with two records buffered discards them and restarts numbering.
    rec_if.rec_ready = 1'b0;
    reg_commit(16'h0300, 16'h0);
    step();
    reg_commit(16'h0302, 16'h0);
    step();
    idle();
    chk("mid_buffered", 32'(rec_if.rec_valid), 32'd1);
    chk("mid_inum", 32'(rec_if.rec_inum), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(rec_if.rec_valid), 32'd0);
    rst = 1'b0;
    reg_commit(16'h0304, 16'h0);
    step();
    idle();
    chk("post_rst_valid", 32'(rec_if.rec_valid), 32'd1);
    chk("post_rst_inum",  32'(rec_if.rec_inum), 32'd0);
    chk("post_rst_pc",    32'(rec_if.rec_pc), 32'h0304);
    chk("post_rst_cycle", rec_if.rec_cycle, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_trace_tx.md
Name: commit_trace_tx

Overview:
- Hardware producer of per-instruction commit records, the transmit end of the commit-trace interface that the trace sink consumes.
- Sits at the writeback boundary of the processor. It samples retire-stage signals, classifies each retired instruction, numbers it, and buffers it.
- Records are emitted over a valid/ready stream to a trace sink (bench logger, UART bridge, or on-chip checker).
- Back-pressures the core when its buffer fills and stops after a halt record drains.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- INUM_W, 16, width of the instruction-number counter.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  16  PC of the retiring instruction
- commit_inst  in  16  instruction word
- reg_write  in  1  register file written
- write_reg  in  3  destination register
- write_data  in  16  register write data
- mem_read  in  1  data-memory read
- mem_write  in  1  data-memory write
- mem_addr  in  16  data-memory address
- mem_data  in  16  store data
- halt  in  1  retiring instruction is HALT
- commit_stall  out  1  buffer full; core must hold the commit
- rec_valid  out  1  record available
- rec_ready  in  1  sink accepts the record
- rec_kind  out  3  record class
- rec_inum  out  INUM_W  instruction number
- rec_pc, rec_inst, rec_wdata, rec_addr, rec_mdata  out  16 each  record payload
- rec_wreg  out  3  destination register
- rec_cycle  out  32  retire-cycle stamp (optional feature)
- halted  out  1  halt record delivered; block idle

Behaviour:
- Reset: all outputs 0, FIFO empty, inum=0, cycle=0, state RUN. Reset mid-operation discards all buffered records.
- Classification, priority top-down:
  - reg_write & mem_write -> STU (3)
  - reg_write & mem_read -> LD (2)
  - reg_write -> REG (1)
  - halt -> HALT (5)
  - mem_write -> ST (4)
  - else NOP (0)
- Payload fields not meaningful for a kind are forced to 0.
- Push: commit_valid & !commit_stall & state==RUN. The record takes the current inum; inum increments by 1 and wraps modulo 2^INUM_W.
- commit_valid while commit_stall=1 is ignored. The core must hold the same commit until the stall clears.
- commit_stall = FIFO full. It is combinational from the occupancy register only and ignores a same-cycle pop.
- Pop: rec_valid & rec_ready. rec_* fields are driven from the FIFO head and stay stable while rec_valid=1 and rec_ready=0.
- Latency: a record pushed in cycle N is visible on rec_valid in cycle N+1. There is no bypass.
- Simultaneous push and pop while not full: occupancy unchanged, order preserved.
- Pop with an empty FIFO is a no-op.
- State machine:
  - RUN: a pushed HALT record moves to DRAIN.
  - DRAIN: commit_valid is ignored. When the HALT record is popped, move to DONE.
  - DONE: halted=1 and rec_valid=0. The block stays in DONE until rst.
- Cycle counter: 32-bit, increments every cycle with rst=0, wraps.

Optional Feature:
- Macro: COMMIT_TRACE_CYCLE_STAMP_EN.
- Defined: each FIFO entry carries a 32-bit cycle stamp, captured as the cycle-counter value in the push cycle, and rec_cycle presents the head entry's stamp.
- Not defined: there is no cycle counter and no stamp storage, and rec_cycle is tied to 0.

Decomposition:
- Package commit_trace_pkg holds:
  - kind constants KIND_NOP..KIND_HALT
  - record field widths
  - the packed record typedef: kind, inum, pc, inst, wreg, wdata, addr, mdata, plus cycle when the macro is defined
- Sub-module trace_fifo: generic synchronous FIFO, parameterised on width and depth. It provides full/empty flags and push/pop inputs, and holds the packed records.
- Classification, counters and the FSM live in commit_trace_tx.

Test Plan:
- Reset then one commit: pc=0x0002, reg_write=1, write_reg=3, write_data=0x00AB. Expect next cycle: rec_valid=1, kind=1, inum=0, pc=0x0002, wreg=3, wdata=0x00AB.
- Store then stu, both with rec_ready=1:
  - st with addr=0x0010, mdata=0x1234 -> kind=4, wreg=0, wdata=0.
  - stu with reg_write=1, mem_write=1 -> kind=3, inum incremented by 1.
- Back-pressure: rec_ready=0 with 5 consecutive commits. commit_stall=1 after the 4th push. The 5th commit is held and not lost. Then raise rec_ready: 5 records emerge in order with inum 0..4 and no duplicates.
- Halt: commit REG, commit HALT, then 2 further commits. Expect exactly 2 records (REG, HALT). halted=1 the cycle after HALT pops. Further commits are ignored.
- Wrap and reset: with INUM_W=4, 17 commits -> the 17th record has inum=0. Then assert rst while 2 records are buffered: rec_valid=0 and the next record has inum=0.
- With COMMIT_TRACE_CYCLE_STAMP_EN defined: a commit in the 7th cycle after reset release gives rec_cycle=6. Without the macro, rec_cycle=0.
